// File: rtl/market_data_pkg.sv
// Shared types and helpers for the market data front end: packer state
// encoding, default word geometry and a saturating counter increment.
package market_data_pkg;

  localparam int unsigned BYTES_PER_WORD = 8;
  localparam int unsigned CNT_W          = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    DISCARD = 2'd2
  } packer_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/market_data_word_packer.sv
// Packs the MAC receive byte stream into DATA_WIDTH beats with sop/eop framing,
// truncating oversize frames and holding one output beat for downstream ready.
module market_data_word_packer
  import market_data_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = BYTES_PER_WORD * 8,
  parameter int unsigned MAX_PACKET_SIZE = 1500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_data,
  input  logic                    rx_last,
  input  logic                    rx_error,
  output logic                    rx_ready,
  output logic                    data_valid,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic [DATA_WIDTH/8-1:0] data_keep,
  output logic                    sop,
  output logic                    eop,
  output logic                    data_err,
  input  logic                    ready,
  output logic [15:0]             frames_packed,
  output logic [15:0]             frames_truncated
);

  localparam int unsigned BYTES  = DATA_WIDTH / 8;
  localparam int unsigned LANE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned CW     = $clog2(MAX_PACKET_SIZE + 1);

  packer_state_e         state;
  logic [DATA_WIDTH-1:0] acc;
  logic [LANE_W-1:0]     lane;
  logic [CW-1:0]         byte_cnt;
  logic                  first;

  logic                  accept;
  logic                  take;
  logic [CW-1:0]         new_cnt;
  logic                  at_max;
  logic                  trunc;
  logic                  emit;
  logic [DATA_WIDTH-1:0] beat;
  logic [BYTES-1:0]      keep;

  // Input stalls only while an unconsumed beat would be overwritten; DISCARD never loads a beat
  assign rx_ready = (state == DISCARD) || !data_valid || ready;
  assign accept   = rx_valid && rx_ready;
  assign take     = accept && (state != DISCARD);
  assign new_cnt  = byte_cnt + CW'(1);
  assign at_max   = (new_cnt == CW'(MAX_PACKET_SIZE));
  assign trunc    = at_max && !rx_last;
  assign emit     = take && ((lane == LANE_W'(BYTES - 1)) || rx_last || at_max);

  // Accumulator with the current byte merged into its lane; lanes above stay zero
  always_comb begin
    beat = acc;
    keep = '0;
    for (int i = 0; i < int'(BYTES); i++) begin
      if (LANE_W'(i) == lane) beat[i*8 +: 8] = rx_data;
      keep[i] = (LANE_W'(i) <= lane);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      acc              <= '0;
      lane             <= '0;
      byte_cnt         <= '0;
      first            <= 1'b1;
      data_valid       <= 1'b0;
      data_out         <= '0;
      data_keep        <= '0;
      sop              <= 1'b0;
      eop              <= 1'b0;
      data_err         <= 1'b0;
      frames_packed    <= '0;
      frames_truncated <= '0;
    end else begin
      if (data_valid && ready && eop) frames_packed <= sat_inc(frames_packed);

      if (emit) begin
        data_valid <= 1'b1;
        data_out   <= beat;
        data_keep  <= keep;
        sop        <= first;
        eop        <= rx_last || trunc;
        data_err   <= rx_last ? rx_error : trunc;
      end else if (data_valid && ready) begin
        data_valid <= 1'b0;
      end

      case (state)
        IDLE, ACCUM: begin
          if (take) begin
            if (rx_last) begin
              state    <= IDLE;
              byte_cnt <= '0;
              lane     <= '0;
              acc      <= '0;
              first    <= 1'b1;
            end else begin
              byte_cnt <= new_cnt;
              if (emit) begin
                acc   <= '0;
                lane  <= '0;
                first <= 1'b0;
              end else begin
                acc  <= beat;
                lane <= lane + LANE_W'(1);
              end
              if (trunc) begin
                state            <= DISCARD;
                frames_truncated <= sat_inc(frames_truncated);
              end else begin
                state <= ACCUM;
              end
            end
          end
        end
        DISCARD: begin
          if (accept && rx_last) begin
            state    <= IDLE;
            byte_cnt <= '0;
            lane     <= '0;
            acc      <= '0;
            first    <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_market_data_word_packer.sv
// Directed self-checking bench for market_data_word_packer.
module tb_market_data_word_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_last;
  logic        rx_error;
  logic        rx_ready;
  logic        data_valid;
  logic [63:0] data_out;
  logic [7:0]  data_keep;
  logic        sop;
  logic        eop;
  logic        data_err;
  logic        ready;
  logic [15:0] frames_packed;
  logic [15:0] frames_truncated;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        s;
    logic        e;
    logic        r;
  } beat_t;

  beat_t beats[$];

  always #5 clk = ~clk;

  market_data_word_packer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .rx_valid         (rx_valid),
    .rx_data          (rx_data),
    .rx_last          (rx_last),
    .rx_error         (rx_error),
    .rx_ready         (rx_ready),
    .data_valid       (data_valid),
    .data_out         (data_out),
    .data_keep        (data_keep),
    .sop              (sop),
    .eop              (eop),
    .data_err         (data_err),
    .ready            (ready),
    .frames_packed    (frames_packed),
    .frames_truncated (frames_truncated)
  );

  // Record every beat that completes a handshake on the following rising edge
  always @(negedge clk) begin
    if (rst_n && data_valid && ready)
      beats.push_back('{d: data_out, k: data_keep, s: sop, e: eop, r: data_err});
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_beat(input string tag, input int idx, input logic [63:0] d,
                            input logic [7:0] k, input logic s, input logic e, input logic r);
    if (idx >= beats.size()) begin
      check($sformatf("%s.missing", tag), 64'(beats.size()), 64'(idx + 1));
    end else begin
      check($sformatf("%s.data", tag), beats[idx].d, d);
      check($sformatf("%s.keep", tag), 64'(beats[idx].k), 64'(k));
      check($sformatf("%s.sop", tag), 64'(beats[idx].s), 64'(s));
      check($sformatf("%s.eop", tag), 64'(beats[idx].e), 64'(e));
      check($sformatf("%s.err", tag), 64'(beats[idx].r), 64'(r));
    end
  endtask

  task automatic put_byte(input logic [7:0] d, input logic l, input logic e, output int n);
    logic took;
    rx_valid = 1'b1;
    rx_data  = d;
    rx_last  = l;
    rx_error = e;
    n        = 0;
    took     = 1'b0;
    while (!took && n < 100) begin
      @(negedge clk);
      took = rx_ready;
      @(posedge clk);
      #1;
      n++;
    end
    rx_valid = 1'b0;
    rx_last  = 1'b0;
    rx_error = 1'b0;
    if (!took) check("rx_accept_timeout", 64'(0), 64'(1));
  endtask

  task automatic send_frame(input int nbytes, input int base, input logic err_last);
    int n;
    for (int i = 0; i < nbytes; i++)
      put_byte(8'(base + i), i == nbytes - 1, err_last && (i == nbytes - 1), n);
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".rx_ready"}, 64'(rx_ready), 64'(1));
    check({tag, ".data_valid"}, 64'(data_valid), 64'(0));
    check({tag, ".data_out"}, data_out, 64'(0));
    check({tag, ".data_keep"}, 64'(data_keep), 64'(0));
    check({tag, ".sop"}, 64'(sop), 64'(0));
    check({tag, ".eop"}, 64'(eop), 64'(0));
    check({tag, ".data_err"}, 64'(data_err), 64'(0));
    check({tag, ".frames_packed"}, 64'(frames_packed), 64'(0));
    check({tag, ".frames_truncated"}, 64'(frames_truncated), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rx_last  = 1'b0;
    rx_error = 1'b0;
    ready    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("in_reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("after_reset");

    // 16-byte frame 00..0F
    beats.delete();
    send_frame(16, 'h00, 1'b0);
    settle();
    check("f16.count", 64'(beats.size()), 64'(2));
    check_beat("f16.b0", 0, 64'h0706050403020100, 8'hFF, 1'b1, 1'b0, 1'b0);
    check_beat("f16.b1", 1, 64'h0F0E0D0C0B0A0908, 8'hFF, 1'b0, 1'b1, 1'b0);
    check("f16.frames_packed", 64'(frames_packed), 64'(1));

    // 3-byte frame A1 B2 C3
    beats.delete();
    put_byte(8'hA1, 1'b0, 1'b0, n);
    put_byte(8'hB2, 1'b0, 1'b0, n);
    put_byte(8'hC3, 1'b1, 1'b0, n);
    settle();
    check("f3.count", 64'(beats.size()), 64'(1));
    check_beat("f3.b0", 0, 64'h0000000000C3B2A1, 8'h07, 1'b1, 1'b1, 1'b0);
    check("f3.frames_packed", 64'(frames_packed), 64'(2));

    // 20-byte frame 10..23 with downstream stalled on the first beat
    beats.delete();
    ready = 1'b0;
    fork
      send_frame(20, 'h10, 1'b0);
      begin
        int w = 0;
        while (!data_valid && w < 50) begin
          @(posedge clk);
          #1;
          w++;
        end
        check("stall.valid", 64'(data_valid), 64'(1));
        repeat (5) begin
          check("stall.rx_ready", 64'(rx_ready), 64'(0));
          check("stall.data", data_out, 64'h1716151413121110);
          check("stall.sop", 64'(sop), 64'(1));
          check("stall.keep", 64'(data_keep), 64'hFF);
          @(posedge clk);
          #1;
        end
        ready = 1'b1;
      end
    join
    settle();
    check("f20.count", 64'(beats.size()), 64'(3));
    check_beat("f20.b0", 0, 64'h1716151413121110, 8'hFF, 1'b1, 1'b0, 1'b0);
    check_beat("f20.b1", 1, 64'h1F1E1D1C1B1A1918, 8'hFF, 1'b0, 1'b0, 1'b0);
    check_beat("f20.b2", 2, 64'h0000000023222120, 8'h0F, 1'b0, 1'b1, 1'b0);
    check("f20.frames_packed", 64'(frames_packed), 64'(3));

    // 1502-byte frame: truncated at 1500, tail dropped while the eop beat is held
    beats.delete();
    for (int i = 0; i < 1500; i++) put_byte(8'(i), 1'b0, 1'b0, n);
    ready = 1'b0;
    check("trunc.valid", 64'(data_valid), 64'(1));
    check("trunc.rx_ready_held", 64'(rx_ready), 64'(1));
    put_byte(8'(1500), 1'b0, 1'b0, n);
    check("trunc.drop1_cycles", 64'(n), 64'(1));
    check("trunc.rx_ready_discard", 64'(rx_ready), 64'(1));
    put_byte(8'(1501), 1'b1, 1'b1, n);
    check("trunc.drop2_cycles", 64'(n), 64'(1));
    check("trunc.held_data", data_out, 64'h00000000DBDAD9D8);
    check("trunc.held_err", 64'(data_err), 64'(1));
    ready = 1'b1;
    settle();
    check("trunc.count", 64'(beats.size()), 64'(188));
    check_beat("trunc.b0", 0, 64'h0706050403020100, 8'hFF, 1'b1, 1'b0, 1'b0);
    check_beat("trunc.b187", 187, 64'h00000000DBDAD9D8, 8'h0F, 1'b0, 1'b1, 1'b1);
    check("trunc.frames_truncated", 64'(frames_truncated), 64'(1));
    check("trunc.frames_packed", 64'(frames_packed), 64'(4));

    // Exactly 1500 bytes: normal frame
    beats.delete();
    send_frame(1500, 'h00, 1'b0);
    settle();
    check("max.count", 64'(beats.size()), 64'(188));
    check_beat("max.b187", 187, 64'h00000000DBDAD9D8, 8'h0F, 1'b0, 1'b1, 1'b0);
    check("max.frames_truncated", 64'(frames_truncated), 64'(1));
    check("max.frames_packed", 64'(frames_packed), 64'(5));

    // 9-byte frame 30..38 with rx_error on the last byte
    beats.delete();
    send_frame(9, 'h30, 1'b1);
    settle();
    check("err.count", 64'(beats.size()), 64'(2));
    check_beat("err.b0", 0, 64'h3736353433323130, 8'hFF, 1'b1, 1'b0, 1'b0);
    check_beat("err.b1", 1, 64'h0000000000000038, 8'h01, 1'b0, 1'b1, 1'b1);
    check("err.frames_packed", 64'(frames_packed), 64'(6));

    // Reset after 5 bytes, then a fresh 8-byte frame
    beats.delete();
    for (int i = 0; i < 5; i++) put_byte(8'(8'h50 + i), 1'b0, 1'b0, n);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midreset.no_beats", 64'(beats.size()), 64'(0));
    send_frame(8, 'h40, 1'b0);
    settle();
    check("post_reset.count", 64'(beats.size()), 64'(1));
    check_beat("post_reset.b0", 0, 64'h4746454443424140, 8'hFF, 1'b1, 1'b1, 1'b0);
    check("post_reset.frames_packed", 64'(frames_packed), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/market_data_word_packer.md
# market_data_word_packer

Upstream feeder of the market data processor: accepts the MAC receive byte stream (8 bits/cycle, ready/valid) and packs it into 64-bit beats with sop/eop framing. Frames longer than MAX_PACKET_SIZE are truncated and flagged. Its output drives the processor's data_valid/data_in/sop/eop inputs directly, with a one-beat output register honouring downstream ready.

## Interface
- DATA_WIDTH, 64, output beat width; must be a multiple of 8 (BYTES = DATA_WIDTH/8).
- MAX_PACKET_SIZE, 1500, maximum bytes forwarded per frame.
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx_valid  in  1  byte present on rx_data.
- rx_data  in  8  receive byte.
- rx_last  in  1  qualifies last byte of frame.
- rx_error  in  1  MAC frame error; sampled only with rx_last.
- rx_ready  out  1  byte accepted when rx_valid && rx_ready.
- data_valid  out  1  output beat valid.
- data_out  out  DATA_WIDTH  packed beat; first byte of beat in [7:0].
- data_keep  out  BYTES  byte-valid mask, contiguous from bit 0.
- sop  out  1  first beat of frame.
- eop  out  1  last beat of frame.
- data_err  out  1  with eop: frame truncated or rx_error seen.
- ready  in  1  downstream accepts beat when data_valid && ready.
- frames_packed  out  16  eop beats handed off, saturating.
- frames_truncated  out  16  oversize frames, saturating.

## Operation
- States: IDLE (no frame open), ACCUM (frame open), DISCARD (dropping oversize tail).
- Accumulator register (DATA_WIDTH), byte lane index (0..BYTES-1), frame byte counter ($clog2(MAX_PACKET_SIZE+1) bits), first-beat flag.
- Accepted byte written to lane index; lane index increments, wraps BYTES-1 -> 0.
- Beat emitted into output register when: lane BYTES-1 is written, or rx_last, or byte counter reaches MAX_PACKET_SIZE. Unused lanes zero; data_keep = (1<<bytes_in_beat)-1.
- sop = first beat of frame; eop = beat containing rx_last or truncation byte. Single-beat frame has sop=eop=1.
- IDLE: first accepted byte -> ACCUM (byte counter = 1). If same byte has rx_last: 1-byte frame emitted, stay IDLE.
- ACCUM: rx_last -> beat with eop, data_err = rx_error, -> IDLE, counters/lane cleared.
- Byte counter == MAX_PACKET_SIZE on an accepted byte without rx_last: beat with eop, data_err=1, frames_truncated++, -> DISCARD. With rx_last on same byte: normal frame, no truncation.
- DISCARD: rx_ready=1 regardless of output state, bytes dropped; rx_last -> IDLE. rx_error in DISCARD ignored.
- frames_packed increments on eop beat handshake (data_valid && ready && eop), including errored frames; both counters hold at 16'hFFFF.

## Timing
- Reset values: rx_ready=1, data_valid=0, data_out=0, data_keep=0, sop=0, eop=0, data_err=0, frames_packed=0, frames_truncated=0; state IDLE, lane/counter 0.
- rx_ready = (state==DISCARD) || !data_valid || ready (combinational); packer stalls all input while an unconsumed beat is held.
- Latency: byte completing a beat accepted at cycle N -> data_valid=1 at N+1.
- data_out/data_keep/sop/eop/data_err held stable while data_valid && !ready.
- Beat handshake and new beat load in same cycle allowed (back-to-back beats, full throughput 1 byte/cycle).
- Reset mid-frame: partial frame discarded, no eop emitted; next accepted byte starts a new frame with sop. Downstream resyncs on sop.

## Structure
- Shared market_data_pkg: packer state enum (IDLE, ACCUM, DISCARD), BYTES_PER_WORD constant, saturating-increment function also usable by processor message counters.
- Single module; no sub-module warranted (output register is a few lines).

## Test plan
- 16-byte frame 0x00..0x0F, ready=1 -> two beats: 64'h0706050403020100 sop=1 keep=FF; 64'h0F0E0D0C0B0A0908 eop=1 keep=FF; frames_packed=1.
- 3-byte frame A1 B2 C3 -> one beat 64'h0000000000C3B2A1, sop=eop=1, keep=07, data_err=0.
- 20-byte frame, ready low 5 cycles at first beat -> beat held stable, rx_ready=0 during stall, no byte loss, third beat keep=0F.
- 1502-byte frame -> 188th beat eop=1 keep=0F data_err=1, last 2 bytes dropped with rx_ready=1, frames_truncated=1; exactly 1500-byte frame -> data_err=0, frames_truncated unchanged.
- 9-byte frame with rx_error on last byte -> second beat keep=01 eop=1 data_err=1, frames_packed increments.
- rst_n asserted after 5 bytes of a frame -> all outputs at reset values; next 8-byte frame emits single beat with sop=eop=1.
